uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 156 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting and a valid/ready word holding register
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_S0 = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_S1 = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] OS_S2 = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic PAR_ODD = PARITY == 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  logic [OW-1:0] os_q, os_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic perr_q, perr_d, ferr_q, ferr_d, any_q, any_d, brk_q, brk_d;
  logic valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic rxs, tick, end_bit, decide, maj, done, load;
  assign rxs = sync_q[1];
  assign tick = div_q == DIV_LAST;
  assign end_bit = tick && os_q == OS_LAST;
  assign decide = tick && os_q == OS_S2;
  assign maj = (smp_q[0] & smp_q[1]) | (rxs & (smp_q[0] | smp_q[1]));
  assign done = state_q == S_STOP && decide && cnt_q == STOP_LAST;
  always_comb begin
    sync_d = {sync_q[0], rx_in};
    state_d = state_q;
    div_d = tick ? '0 : div_q + 1'b1;
    os_d = end_bit ? '0 : tick ? os_q + 1'b1 : os_q;
    cnt_d = cnt_q;
    smp_d = smp_q;
    sh_d = sh_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    any_d = any_q;
    brk_d = brk_q;
    if (tick && os_q == OS_S0) smp_d[0] = rxs;
    if (tick && os_q == OS_S1) smp_d[1] = rxs;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        any_d = 1'b0;
        if (brk_q) brk_d = ~rxs;
        else if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (decide && maj) state_d = S_IDLE;
        else if (end_bit) state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          sh_d = {maj, sh_q[DATA_BITS-1:1]};
          any_d = any_q | maj;
        end
        if (end_bit) begin
          cnt_d = cnt_q == DATA_LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) state_d = PARITY != 0 ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d = (^sh_q ^ maj) != PAR_ODD;
          any_d = any_q | maj;
        end
        if (end_bit) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) ferr_d = ferr_q | ~maj;
        // leave at the last stop-bit decision so a back-to-back start edge is seen
        if (done) begin
          state_d = S_IDLE;
          brk_d = ~(any_q | maj);
        end else if (end_bit) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      div_d = '0;
      os_d = '0;
    end
    load = done && (!valid_q || ready);
    data_d = load ? sh_q : data_q;
    pe_d = load ? perr_q : pe_q;
    fe_d = load ? ferr_d : fe_q;
    valid_d = load | (valid_q & ~ready);
    ovr_d = done & ~load;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      state_q <= S_IDLE;
      div_q <= '0;
      os_q <= '0;
      cnt_q <= '0;
      smp_q <= '0;
      sh_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      any_q <= 1'b0;
      brk_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      div_q <= div_d;
      os_q <= os_d;
      cnt_q <= cnt_d;
      smp_q <= smp_d;
      sh_q <= sh_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      any_q <= any_d;
      brk_q <= brk_d;
      data_q <= data_d;
      valid_q <= valid_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      ovr_q <= ovr_d;
    end
  end
  assign data_out = data_q;
  assign valid = valid_q;
  assign parity_err = pe_q;
  assign framing_err = fe_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: four receiver configurations driven with directed and random frames, checked against a frame-level model
module tb_uart_rx_cfg;
  timeunit 1ns;
  timeprecision 1ns;
  localparam int NI = 4;
  localparam int BIT_CLKS = 16;
  int nd [NI] = '{8, 8, 7, 9};
  int pm [NI] = '{0, 2, 0, 1};
  int sb [NI] = '{1, 1, 2, 2};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] rx = '1;
  logic [NI-1:0] rdy = '1;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] d3;
  logic [NI-1:0] vx, pex, fex, ovx;
  logic [8:0] dx [NI];
  int gotq [NI][$];
  int expq [NI][$];
  int vhi [NI] = '{0, 0, 0, 0};
  int ovn [NI] = '{0, 0, 0, 0};
  int lat [NI] = '{0, 0, 0, 0};
  longint t_stop [NI] = '{0, 0, 0, 0};
  logic [NI-1:0] vprev = '0;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  assign dx[0] = 9'(d0);
  assign dx[1] = 9'(d1);
  assign dx[2] = 9'(d2);
  assign dx[3] = 9'(d3);
  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16)) u0 (
    .clk(clk), .rst(rst), .rx_in(rx[0]), .data_out(d0), .valid(vx[0]), .ready(rdy[0]),
    .parity_err(pex[0]), .framing_err(fex[0]), .overrun(ovx[0]));
  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .PARITY(2)) u1 (
    .clk(clk), .rst(rst), .rx_in(rx[1]), .data_out(d1), .valid(vx[1]), .ready(rdy[1]),
    .parity_err(pex[1]), .framing_err(fex[1]), .overrun(ovx[1]));
  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(7), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx_in(rx[2]), .data_out(d2), .valid(vx[2]), .ready(rdy[2]),
    .parity_err(pex[2]), .framing_err(fex[2]), .overrun(ovx[2]));
  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .rx_in(rx[3]), .data_out(d3), .valid(vx[3]), .ready(rdy[3]),
    .parity_err(pex[3]), .framing_err(fex[3]), .overrun(ovx[3]));
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (vx[i] && !vprev[i]) lat[i] = int'(($time - t_stop[i]) / 10);
      if (vx[i]) vhi[i]++;
      if (ovx[i]) ovn[i]++;
      if (vx[i] && rdy[i]) gotq[i].push_back(int'(dx[i]) | (int'(pex[i]) << 9) | (int'(fex[i]) << 10));
    end
    vprev = vx;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [8:0] masked(input int i, input logic [8:0] d);
    return d & 9'((1 << nd[i]) - 1);
  endfunction
  function automatic int flen(input int i);
    return 1 + nd[i] + (pm[i] != 0 ? 1 : 0) + sb[i];
  endfunction
  // line bits LSB first: start, data, optional parity (inverted when pflip), stop bits taken from stop[]
  function automatic logic [15:0] mk_frame(input int i, input logic [8:0] d, input bit pflip, input logic [1:0] stop);
    logic [15:0] f;
    logic [8:0] m;
    int k;
    f = '1;
    m = masked(i, d);
    f[0] = 1'b0;
    for (int b = 0; b < nd[i]; b++) f[1 + b] = m[b];
    k = 1 + nd[i];
    if (pm[i] != 0) begin
      f[k] = (^m) ^ (pm[i] == 1) ^ pflip;
      k++;
    end
    for (int s = 0; s < sb[i]; s++) f[k + s] = stop[s];
    return f;
  endfunction
  function automatic int exp_word(input int i, input logic [8:0] d, input bit pflip, input logic [1:0] stop);
    bit fe;
    bit pe;
    fe = 1'b0;
    for (int s = 0; s < sb[i]; s++) if (!stop[s]) fe = 1'b1;
    pe = pm[i] != 0 && pflip;
    return int'(masked(i, d)) | (int'(pe) << 9) | (int'(fe) << 10);
  endfunction
  task automatic send(input int i, input logic [8:0] d, input bit pflip, input logic [1:0] stop, input int gap, input bit push);
    logic [15:0] f;
    int n;
    f = mk_frame(i, d, pflip, stop);
    n = flen(i);
    if (push) expq[i].push_back(exp_word(i, d, pflip, stop));
    for (int b = 0; b < n; b++) begin
      if (b == n - 1) t_stop[i] = $time;
      rx[i] = f[b];
      step(BIT_CLKS);
    end
    rx[i] = 1'b1;
    step(BIT_CLKS * gap);
  endtask
  task automatic drain(input int i);
    while (expq[i].size() > 0) begin
      if (gotq[i].size() == 0) check($sformatf("missing_word%0d", i), 32'hffff_ffff, expq[i].pop_front());
      else check($sformatf("word%0d", i), gotq[i].pop_front(), expq[i].pop_front());
    end
    check($sformatf("extra_words%0d", i), gotq[i].size(), 0);
  endtask
  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s%0d", tag, i), {vx[i], pex[i], fex[i], ovx[i], dx[i]}, 0);
  endtask
  initial begin
    int v0;
    int o0;
    logic [15:0] f;
    logic [8:0] d;
    bit pf;
    logic [1:0] st;
    step(3);
    check_zero("rst_out");
    rst = 1'b0;
    step(BIT_CLKS * 2);
    v0 = vhi[0];
    send(0, 9'hA5, 1'b0, 2'b11, 2, 1'b1);
    check("a5_valid_cycles", vhi[0] - v0, 1);
    check("a5_latency_in_window", lat[0] >= 8 && lat[0] <= 14, 1);
    drain(0);
    send(1, 9'h37, 1'b0, 2'b11, 2, 1'b1);
    send(1, 9'h37, 1'b1, 2'b11, 2, 1'b1);
    drain(1);
    v0 = vhi[0];
    rx[0] = 1'b0;
    step(4);
    rx[0] = 1'b1;
    step(BIT_CLKS * 2);
    check("glitch_no_valid", vhi[0] - v0, 0);
    send(0, 9'h5A, 1'b0, 2'b11, 2, 1'b1);
    drain(0);
    rdy[0] = 1'b0;
    o0 = ovn[0];
    send(0, 9'h11, 1'b0, 2'b11, 0, 1'b1);
    send(0, 9'h22, 1'b0, 2'b11, 2, 1'b0);
    check("ovr_hold_data", dx[0], 9'h11);
    check("ovr_hold_valid", vx[0], 1);
    check("ovr_pulse_cycles", ovn[0] - o0, 1);
    rdy[0] = 1'b1;
    step(2);
    check("ovr_valid_drop", vx[0], 0);
    drain(0);
    send(2, 9'h3C, 1'b0, 2'b01, 3, 1'b1);
    drain(2);
    // break: all-zero frame, line held low afterwards must not start a new frame
    send(0, 9'h00, 1'b0, 2'b00, 0, 1'b1);
    rx[0] = 1'b0;
    step(BIT_CLKS * 3);
    rx[0] = 1'b1;
    step(BIT_CLKS * 2);
    send(0, 9'h81, 1'b0, 2'b11, 2, 1'b1);
    drain(0);
    rdy[0] = 1'b0;
    send(0, 9'h77, 1'b0, 2'b11, 1, 1'b0);
    check("pre_rst_valid", vx[0], 1);
    f = mk_frame(0, 9'h99, 1'b0, 2'b11);
    for (int b = 0; b < 5; b++) begin
      rx[0] = f[b];
      step(BIT_CLKS);
    end
    rx[0] = f[5];
    step(BIT_CLKS / 2);
    rst = 1'b1;
    #1;
    check_zero("async_rst_out");
    step(1);
    rst = 1'b0;
    rx[0] = 1'b1;
    rdy[0] = 1'b1;
    step(BIT_CLKS * 2);
    send(0, 9'h42, 1'b0, 2'b11, 2, 1'b1);
    drain(0);
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 12; n++) begin
        d = 9'($urandom);
        pf = $urandom_range(0, 3) == 0;
        st = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b11;
        send(i, d, pf, st, $urandom_range(2, 4), 1'b1);
      end
      drain(i);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
